processor_pio_debounce: RTL and testbench

// - Conditions raw asynchronous board inputs (push-buttons/switches) before

---
 rtl/processor_pio_debounce.sv | 133 +++++++++++++
 tb/tb_processor_pio_debounce.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_pio_debounce.sv
// processor_pio_debounce
//
// Conditions raw asynchronous board inputs (push-buttons, switches) before
// they reach the processor's Avalon input PIO. Each bit has its own
// synchroniser, debounce counter and rise/fall pulse generator. All bits
// are independent of each other.
//
// Optional feature macro: PIO_DEBOUNCE_EDGE_IRQ_EN
//   When this macro is defined, the block adds sticky rising-edge capture
//   flags with write-1-to-clear, plus an interrupt request output.
//
// Parameters
//   WIDTH            number of independent input bits
//   SYNC_STAGES      synchroniser flops per bit (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing samples needed to commit (>= 1)
//   RESET_VALUE      reset level of the sync chain and of debounced_out
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   raw_in         in   asynchronous raw pin levels
//   debounced_out  out  committed stable levels, drives PIO in_port
//   rise_pulse     out  one-cycle pulse on a committed 0->1 transition
//   fall_pulse     out  one-cycle pulse on a committed 1->0 transition
//   edge_clear     in   write-1-to-clear for edge_capture  (macro only)
//   edge_capture   out  sticky rising-edge flags           (macro only)
//   irq            out  OR of edge_capture                 (macro only)
//
// Per-bit debounce FSM
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_STABLE    | synchronised input matches debounced_out, counter idle
//   ST_COUNTING  | input differs from debounced_out, counting stable samples

module processor_pio_debounce #(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
    ,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
`endif
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit            ONE_SHOT = (DEBOUNCE_CYCLES == 1);

    typedef enum logic {
        ST_STABLE,
        ST_COUNTING
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    state_t           state  [WIDTH];
    logic [CW-1:0]    cnt    [WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
            debounced_out <= RESET_VALUE;
            rise_pulse    <= '0;
            fall_pulse    <= '0;
        end else begin
            // Pulses default low so each one lasts exactly one cycle.
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == debounced_out[i]) begin
                    // Either already stable or a glitch ended before commit.
                    state[i] <= ST_STABLE;
                    cnt[i]   <= '0;
                end else if ((state[i] == ST_STABLE && ONE_SHOT) ||
                             (state[i] == ST_COUNTING && cnt[i] == CNT_LAST)) begin
                    debounced_out[i] <= s[i];
                    rise_pulse[i]    <= s[i];
                    fall_pulse[i]    <= ~s[i];
                    state[i]         <= ST_STABLE;
                    cnt[i]           <= '0;
                end else if (state[i] == ST_STABLE) begin
                    state[i] <= ST_COUNTING;
                    cnt[i]   <= CNT_ONE;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
    // A rise pulse arriving in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | rise_pulse;
        end
    end

    assign irq = |edge_capture;
`endif

endmodule

// File: tb/tb_processor_pio_debounce.sv
module tb_processor_pio_debounce;

    localparam int               W   = 4;
    localparam int               SS  = 2;
    localparam int               DC  = 4;
    localparam logic [W-1:0]     RV  = '0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] raw_in = '1;
    logic [W-1:0] debounced_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
    logic [W-1:0] edge_clear = '0;
    logic [W-1:0] edge_capture;
    logic         irq;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 0;

    // Reference model state: a pure delay line for the synchroniser and a
    // window of the last DC samples the debouncer has seen since reset.
    logic [W-1:0] sync_m [SS];
    logic [W-1:0] hist_m [DC];
    int           nseen;
    logic [W-1:0] deb_m, rise_m, fall_m, ec_m;

    processor_pio_debounce #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .RESET_VALUE(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_in(raw_in),
        .debounced_out(debounced_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
        ,
        .edge_clear(edge_clear),
        .edge_capture(edge_capture),
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advances the model by one rising edge using the inputs currently applied.
    // A bit commits when every one of the last DC observed samples differs
    // from its current debounced level.
    task automatic model_edge();
        logic [W-1:0] s_now, nd, nr, nf;
        logic         all_diff;
        if (reset) begin
            for (int k = 0; k < SS; k++) sync_m[k] = RV;
            deb_m  = RV;
            rise_m = '0;
            fall_m = '0;
            ec_m   = '0;
            nseen  = 0;
        end else begin
            s_now = sync_m[SS-1];
            for (int k = DC-1; k > 0; k--) hist_m[k] = hist_m[k-1];
            hist_m[0] = s_now;
            if (nseen < DC) nseen++;
            nd = deb_m;
            nr = '0;
            nf = '0;
            for (int i = 0; i < W; i++) begin
                all_diff = (nseen >= DC);
                for (int k = 0; k < DC; k++) begin
                    if (hist_m[k][i] == deb_m[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    nd[i] = ~deb_m[i];
                    if (nd[i]) nr[i] = 1'b1;
                    else       nf[i] = 1'b1;
                end
            end
`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
            ec_m = (ec_m & ~edge_clear) | rise_m;
`endif
            deb_m  = nd;
            rise_m = nr;
            fall_m = nf;
            for (int k = SS-1; k > 0; k--) sync_m[k] = sync_m[k-1];
            sync_m[0] = raw_in;
        end
    endtask

    task automatic tick();
        if (reset) checking = 1;
        model_edge();
        @(posedge clk);
        #1;
        if (checking) begin
            check("debounced", debounced_out, deb_m);
            check("rise", rise_pulse, rise_m);
            check("fall", fall_pulse, fall_m);
            check("rise_and_fall", rise_pulse & fall_pulse, '0);
`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
            check("edge_capture", edge_capture, ec_m);
            check("irq", {3'b000, irq}, {3'b000, |ec_m});
`endif
        end
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        logic [W-1:0] seen;
        int hold [W];

        // Reset with all inputs high
        #1;
        raw_in = 4'hF;
        reset  = 1'b1;
        ticks(3);
        check("reset_deb", debounced_out, 4'h0);
        check("reset_pulses", rise_pulse | fall_pulse, 4'h0);
        reset = 1'b0;
        ticks(5);
        check("post_reset_wait", debounced_out, 4'h0);
        tick();
        check("post_reset_deb", debounced_out, 4'hF);
        check("post_reset_rise", rise_pulse, 4'hF);
        tick();
        check("post_reset_rise_end", rise_pulse, 4'h0);

        // Glitch on bit 0
        raw_in = 4'h0;
        ticks(8);
        check("all_low", debounced_out, 4'h0);
        raw_in = 4'h1;
        ticks(3);
        raw_in = 4'h0;
        seen = '0;
        for (int j = 0; j < 8; j++) begin
            tick();
            seen |= rise_pulse | fall_pulse | debounced_out;
        end
        check("glitch_rejected", seen, 4'h0);

        // Clean press and release on bit 2
        raw_in = 4'h4;
        ticks(5);
        check("press_wait", debounced_out, 4'h0);
        tick();
        check("press_deb", debounced_out, 4'h4);
        check("press_rise", rise_pulse, 4'h4);
        ticks(4);
        raw_in = 4'h0;
        ticks(5);
        check("release_wait", debounced_out, 4'h4);
        tick();
        check("release_fall", fall_pulse, 4'h4);
        check("release_deb", debounced_out, 4'h0);
        tick();
        check("release_fall_end", fall_pulse, 4'h0);

        // Independence: bit 1 then bit 3 two cycles later
        raw_in = 4'h2;
        ticks(2);
        raw_in = 4'hA;
        ticks(4);
        check("indep_rise1", rise_pulse, 4'h2);
        ticks(2);
        check("indep_rise3", rise_pulse, 4'h8);
        check("indep_deb", debounced_out, 4'hA);
        raw_in = 4'h0;
        ticks(10);

        // Reset in the middle of a count
        raw_in = 4'h1;
        ticks(4);
        reset = 1'b1;
        tick();
        check("midreset_deb", debounced_out, 4'h0);
        reset = 1'b0;
        seen = '0;
        for (int j = 0; j < 5; j++) begin
            tick();
            seen |= rise_pulse | debounced_out;
        end
        check("midreset_no_commit", seen, 4'h0);
        tick();
        check("midreset_deb_late", debounced_out, 4'h1);
        check("midreset_rise_late", rise_pulse, 4'h1);
        raw_in = 4'h0;
        ticks(8);

`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
        raw_in = 4'h8;
        ticks(7);
        check("ec_set", edge_capture, 4'h8);
        check("irq_set", {3'b000, irq}, 4'h1);
        raw_in = 4'h0;
        ticks(6);
        raw_in = 4'h8;
        ticks(6);
        check("ec_second_rise", rise_pulse, 4'h8);
        edge_clear = 4'h8;
        tick();
        edge_clear = 4'h0;
        check("ec_set_wins", edge_capture, 4'h8);
        edge_clear = 4'h8;
        tick();
        edge_clear = 4'h0;
        check("ec_cleared", edge_capture, 4'h0);
        check("irq_cleared", {3'b000, irq}, 4'h0);
        raw_in = 4'h0;
        ticks(8);
`endif

        // Randomised bouncing with occasional resets
        for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 7);
        for (int j = 0; j < 1500; j++) begin
            for (int i = 0; i < W; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    raw_in[i] = ~raw_in[i];
                    hold[i] = $urandom_range(1, 7);
                end
            end
            reset = ($urandom_range(0, 299) == 0);
`ifdef PIO_DEBOUNCE_EDGE_IRQ_EN
            edge_clear = W'($urandom_range(0, 15)) & W'($urandom_range(0, 15));
`endif
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
